fetch_buffer: RTL

Instruction prefetch queue between the instruction memory and the IF/ID pipeline register. It owns the fetch PC and reads one instruction per cycle from the combinational instruction memory. Each instruction is pushed, with its PC+4, into a small FIFO. The head entry is presented to the IF/ID stage under a valid/ready handshake, so decode stalls no longer freeze fetch. A redirect from the EX/MEM stage (taken branch or jump) flushes the queue and restarts fetch at the target.

---
 rtl/fetch_buffer.sv | 87 ++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue: owns the fetch PC, captures one instruction per cycle
// with its PC+4, and presents the oldest entry to IF/ID under a valid/ready handshake.
module fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [31:0]                    imemAddr,
  input  logic [31:0]                    imemData,
  input  logic                           redirect,
  input  logic [31:0]                    redirectTarget,
  output logic                           outValid,
  input  logic                           outReady,
  output logic [31:0]                    outInstr,
  output logic [31:0]                    outPcPlusFour,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      mem_q [DEPTH];

  logic        pop;
  logic        push;
  logic [31:0] pc_plus_four;

  assign pc_plus_four = fetch_pc_q + 32'd4;

  always_comb begin
    pop        = outValid & outReady;
    push       = !redirect & ((count_q < CNT_W'(DEPTH)) | pop);
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      // A same-cycle pop is still seen by the consumer; the flush discards the rest.
      fetch_pc_d = redirectTarget;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = pc_plus_four;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {pc_plus_four, imemData};
    end
  end

  assign imemAddr      = fetch_pc_q;
  assign count         = count_q;
  assign outValid      = (count_q != '0);
  assign outInstr      = outValid ? mem_q[rd_ptr_q][31:0]  : 32'h0;
  assign outPcPlusFour = outValid ? mem_q[rd_ptr_q][63:32] : 32'h0;

endmodule
